// File: rtl/ex_operand_stage.sv
// Purpose : ID/EX stage register with operand forwarding and load-use hazard detection.
// Latency : one cycle from the ID capture edge to the EX outputs; forwarding muxes add no latency.
// Backpressure: stall holds the stage register; loadUse_stall inserts a bubble while ID holds its instruction.
//
// Ports:
//   clk, rst_n                         clock, asynchronous active-low reset
//   id_*                               decoded instruction from ID
//   stall, flush                       downstream hold request, kill of the incoming instruction
//   exmem_*, memwb_*                   forwarding sources from later pipeline stages
//   ex_*                               registered control plus forwarded ALU operands and store data
//   loadUse_stall                      combinational hazard request back to fetch/decode
module ex_operand_stage #(
    parameter int XLEN = 32,
    parameter int RA_W = 5
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            id_valid,
    input  logic [XLEN-1:0] id_pc,
    input  logic [XLEN-1:0] id_rs1Data,
    input  logic [XLEN-1:0] id_rs2Data,
    input  logic [XLEN-1:0] id_imm,
    input  logic [RA_W-1:0] id_rs1,
    input  logic [RA_W-1:0] id_rs2,
    input  logic [RA_W-1:0] id_rd,
    input  logic [3:0]      id_aluOP,
    input  logic            id_aluSrc,
    input  logic            id_regWrite,
    input  logic            id_memRead,
    input  logic            id_memWrite,
    input  logic            stall,
    input  logic            flush,
    input  logic            exmem_regWrite,
    input  logic [RA_W-1:0] exmem_rd,
    input  logic [XLEN-1:0] exmem_result,
    input  logic            memwb_regWrite,
    input  logic [RA_W-1:0] memwb_rd,
    input  logic [XLEN-1:0] memwb_result,
    output logic            ex_valid,
    output logic            ex_regWrite,
    output logic            ex_memRead,
    output logic            ex_memWrite,
    output logic [XLEN-1:0] ex_a,
    output logic [XLEN-1:0] ex_b,
    output logic [XLEN-1:0] ex_storeData,
    output logic [XLEN-1:0] ex_pc,
    output logic [3:0]      ex_aluOP,
    output logic [RA_W-1:0] ex_rd,
    output logic            loadUse_stall
);

    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] pc;
        logic [RA_W-1:0] rs1;
        logic [RA_W-1:0] rs2;
        logic [RA_W-1:0] rd;
        logic [XLEN-1:0] rs1_dat;
        logic [XLEN-1:0] rs2_dat;
        logic [XLEN-1:0] imm;
        logic [3:0]      aluop;
        logic            alusrc;
        logic            regwrite;
        logic            memread;
        logic            memwrite;
    } stage_t;

    stage_t stage_q;
    stage_t id_dat;

    logic [XLEN-1:0] fwd1;
    logic [XLEN-1:0] fwd2;

    always_comb begin
        id_dat          = '0;
        id_dat.valid    = id_valid;
        id_dat.pc       = id_pc;
        id_dat.rs1      = id_rs1;
        id_dat.rs2      = id_rs2;
        id_dat.rd       = id_rd;
        id_dat.rs1_dat  = id_rs1Data;
        id_dat.rs2_dat  = id_rs2Data;
        id_dat.imm      = id_imm;
        id_dat.aluop    = id_aluOP;
        id_dat.alusrc   = id_aluSrc;
        id_dat.regwrite = id_regWrite;
        id_dat.memread  = id_memRead;
        id_dat.memwrite = id_memWrite;
    end

    // A load in EX cannot supply its data to the instruction right behind it;
    // a flush kills that instruction anyway, so no hazard is raised then.
    assign loadUse_stall = id_valid & stage_q.valid & stage_q.memread &
                           (stage_q.rd != '0) &
                           ((id_rs1 == stage_q.rd) | (id_rs2 == stage_q.rd)) &
                           ~flush;

    // Priority: flush > stall > load-use bubble > capture. An invalid ID
    // instruction is loaded as an all-zero bubble so no stale fields leak.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage_q <= '0;
        end else if (flush) begin
            stage_q <= '0;
        end else if (stall) begin
            stage_q <= stage_q;
        end else if (loadUse_stall) begin
            stage_q <= '0;
        end else if (id_valid) begin
            stage_q <= id_dat;
        end else begin
            stage_q <= '0;
        end
    end

    // EX/MEM is the younger result and wins over MEM/WB; x0 is never forwarded.
    always_comb begin
        fwd1 = stage_q.rs1_dat;
        if (exmem_regWrite && (exmem_rd != '0) && (exmem_rd == stage_q.rs1))
            fwd1 = exmem_result;
        else if (memwb_regWrite && (memwb_rd != '0) && (memwb_rd == stage_q.rs1))
            fwd1 = memwb_result;
    end

    always_comb begin
        fwd2 = stage_q.rs2_dat;
        if (exmem_regWrite && (exmem_rd != '0) && (exmem_rd == stage_q.rs2))
            fwd2 = exmem_result;
        else if (memwb_regWrite && (memwb_rd != '0) && (memwb_rd == stage_q.rs2))
            fwd2 = memwb_result;
    end

    assign ex_a         = fwd1;
    assign ex_b         = stage_q.alusrc ? stage_q.imm : fwd2;
    assign ex_storeData = fwd2;

    assign ex_valid    = stage_q.valid;
    assign ex_regWrite = stage_q.regwrite;
    assign ex_memRead  = stage_q.memread;
    assign ex_memWrite = stage_q.memwrite;
    assign ex_pc       = stage_q.pc;
    assign ex_aluOP    = stage_q.aluop;
    assign ex_rd       = stage_q.rd;

endmodule

// File: tb/tb_ex_operand_stage.sv
module tb_ex_operand_stage;

    logic        clk;
    logic        rst_n;
    logic        id_valid;
    logic [31:0] id_pc, id_rs1Data, id_rs2Data, id_imm;
    logic [4:0]  id_rs1, id_rs2, id_rd;
    logic [3:0]  id_aluOP;
    logic        id_aluSrc, id_regWrite, id_memRead, id_memWrite;
    logic        stall, flush;
    logic        exmem_regWrite;
    logic [4:0]  exmem_rd;
    logic [31:0] exmem_result;
    logic        memwb_regWrite;
    logic [4:0]  memwb_rd;
    logic [31:0] memwb_result;
    logic        ex_valid, ex_regWrite, ex_memRead, ex_memWrite;
    logic [31:0] ex_a, ex_b, ex_storeData, ex_pc;
    logic [3:0]  ex_aluOP;
    logic [4:0]  ex_rd;
    logic        loadUse_stall;

    int n_assert = 0;
    int n_fail   = 0;

    ex_operand_stage #(.XLEN(32), .RA_W(5)) dut (
        .clk(clk), .rst_n(rst_n),
        .id_valid(id_valid), .id_pc(id_pc), .id_rs1Data(id_rs1Data), .id_rs2Data(id_rs2Data),
        .id_imm(id_imm), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .id_aluOP(id_aluOP),
        .id_aluSrc(id_aluSrc), .id_regWrite(id_regWrite), .id_memRead(id_memRead),
        .id_memWrite(id_memWrite), .stall(stall), .flush(flush),
        .exmem_regWrite(exmem_regWrite), .exmem_rd(exmem_rd), .exmem_result(exmem_result),
        .memwb_regWrite(memwb_regWrite), .memwb_rd(memwb_rd), .memwb_result(memwb_result),
        .ex_valid(ex_valid), .ex_regWrite(ex_regWrite), .ex_memRead(ex_memRead),
        .ex_memWrite(ex_memWrite), .ex_a(ex_a), .ex_b(ex_b), .ex_storeData(ex_storeData),
        .ex_pc(ex_pc), .ex_aluOP(ex_aluOP), .ex_rd(ex_rd), .loadUse_stall(loadUse_stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_id(input logic v, input logic [31:0] pc, input logic [4:0] rs1,
                          input logic [4:0] rs2, input logic [4:0] rd,
                          input logic [31:0] d1, input logic [31:0] d2, input logic [31:0] imm,
                          input logic [3:0] op, input logic src, input logic rw,
                          input logic mr, input logic mw);
        id_valid = v; id_pc = pc; id_rs1 = rs1; id_rs2 = rs2; id_rd = rd;
        id_rs1Data = d1; id_rs2Data = d2; id_imm = imm; id_aluOP = op;
        id_aluSrc = src; id_regWrite = rw; id_memRead = mr; id_memWrite = mw;
    endtask

    task automatic set_fwd(input logic ew, input logic [4:0] erd, input logic [31:0] eres,
                           input logic mw, input logic [4:0] mrd, input logic [31:0] mres);
        exmem_regWrite = ew; exmem_rd = erd; exmem_result = eres;
        memwb_regWrite = mw; memwb_rd = mrd; memwb_result = mres;
    endtask

    initial begin
        rst_n = 1'b0; stall = 1'b0; flush = 1'b0;
        set_id(1'b1, 32'h10, 5'd1, 5'd2, 5'd3, 32'h1, 32'h2, 32'h0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        set_fwd(1'b1, 5'd5, 32'h55, 1'b1, 5'd6, 32'h66);
        #1;
        // Reset state: bubble, no hazard, forwarding suppressed since rs1=rs2=0
        chk("rst_ex_valid", {31'd0, ex_valid}, 32'd0);
        chk("rst_ex_regWrite", {31'd0, ex_regWrite}, 32'd0);
        chk("rst_ex_pc", ex_pc, 32'd0);
        chk("rst_ex_rd", {27'd0, ex_rd}, 32'd0);
        chk("rst_ex_aluOP", {28'd0, ex_aluOP}, 32'd0);
        chk("rst_loadUse", {31'd0, loadUse_stall}, 32'd0);
        chk("rst_ex_a", ex_a, 32'd0);
        chk("rst_ex_b", ex_b, 32'd0);
        #2 rst_n = 1'b1;

        // Basic capture
        set_fwd(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        set_id(1'b1, 32'h100, 5'd1, 5'd2, 5'd3, 32'd5, 32'd7, 32'h0, 4'd2, 1'b0, 1'b1, 1'b0, 1'b0);
        tick();
        chk("cap_ex_a", ex_a, 32'd5);
        chk("cap_ex_b", ex_b, 32'd7);
        chk("cap_ex_aluOP", {28'd0, ex_aluOP}, 32'd2);
        chk("cap_ex_valid", {31'd0, ex_valid}, 32'd1);
        chk("cap_ex_pc", ex_pc, 32'h100);
        chk("cap_ex_rd", {27'd0, ex_rd}, 32'd3);
        chk("cap_ex_storeData", ex_storeData, 32'd7);

        // Forwarding priority
        set_id(1'b1, 32'h104, 5'd3, 5'd0, 5'd6, 32'h11, 32'h22, 32'h0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        tick();
        set_fwd(1'b1, 5'd3, 32'hAA, 1'b1, 5'd3, 32'hBB);
        #1 chk("fwd_exmem_wins", ex_a, 32'hAA);
        exmem_regWrite = 1'b0;
        #1 chk("fwd_memwb", ex_a, 32'hBB);
        set_fwd(1'b1, 5'd0, 32'hAA, 1'b1, 5'd0, 32'hBB);
        #1 chk("fwd_rd0_a", ex_a, 32'h11);
        chk("fwd_rs2_zero", ex_b, 32'h22);
        set_id(1'b1, 32'h108, 5'd0, 5'd0, 5'd6, 32'h33, 32'h44, 32'h0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        tick();
        chk("fwd_rs1_zero", ex_a, 32'h33);

        // Load-use hazard
        set_fwd(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        set_id(1'b1, 32'h200, 5'd1, 5'd0, 5'd4, 32'h40, 32'h0, 32'h8, 4'd0, 1'b1, 1'b1, 1'b1, 1'b0);
        tick();
        chk("ld_ex_memRead", {31'd0, ex_memRead}, 32'd1);
        set_id(1'b1, 32'h204, 5'd5, 5'd4, 5'd7, 32'h10, 32'h99, 32'h0, 4'd1, 1'b0, 1'b1, 1'b0, 1'b0);
        #1 chk("lu_stall", {31'd0, loadUse_stall}, 32'd1);
        tick();
        chk("lu_bubble_valid", {31'd0, ex_valid}, 32'd0);
        chk("lu_bubble_regWrite", {31'd0, ex_regWrite}, 32'd0);
        chk("lu_released", {31'd0, loadUse_stall}, 32'd0);
        set_fwd(1'b1, 5'd4, 32'h1234, 1'b0, 5'd0, 32'h0);
        tick();
        chk("lu_cap_valid", {31'd0, ex_valid}, 32'd1);
        chk("lu_cap_pc", ex_pc, 32'h204);
        chk("lu_fwd_b", ex_b, 32'h1234);
        chk("lu_a", ex_a, 32'h10);

        // Immediate path with forwarded store data
        set_id(1'b1, 32'h300, 5'd0, 5'd9, 5'd8, 32'h0, 32'h5, 32'hFFFFFFF0, 4'd3, 1'b1, 1'b0, 1'b0, 1'b1);
        tick();
        set_fwd(1'b1, 5'd9, 32'h12, 1'b0, 5'd0, 32'h0);
        #1 chk("imm_ex_b", ex_b, 32'hFFFFFFF0);
        chk("imm_storeData", ex_storeData, 32'h12);
        chk("imm_memWrite", {31'd0, ex_memWrite}, 32'd1);

        // Stall holds for 3 cycles, then stall+flush loads a bubble
        stall = 1'b1;
        set_id(1'b1, 32'h400, 5'd1, 5'd2, 5'd10, 32'h1, 32'h2, 32'h0, 4'd5, 1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_pc", ex_pc, 32'h300);
            chk("stall_aluOP", {28'd0, ex_aluOP}, 32'd3);
        end
        flush = 1'b1;
        tick();
        chk("flush_valid", {31'd0, ex_valid}, 32'd0);
        chk("flush_pc", ex_pc, 32'd0);
        chk("flush_aluOP", {28'd0, ex_aluOP}, 32'd0);
        stall = 1'b0; flush = 1'b0;

        // Asynchronous reset between edges, then normal capture on release
        set_fwd(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        tick();
        chk("pre_rst_valid", {31'd0, ex_valid}, 32'd1);
        #2 rst_n = 1'b0;
        #1 chk("async_rst_valid", {31'd0, ex_valid}, 32'd0);
        chk("async_rst_pc", ex_pc, 32'd0);
        #1 rst_n = 1'b1;
        set_id(1'b1, 32'h500, 5'd1, 5'd2, 5'd11, 32'h77, 32'h2, 32'h0, 4'd4, 1'b0, 1'b1, 1'b0, 1'b0);
        tick();
        chk("post_rst_valid", {31'd0, ex_valid}, 32'd1);
        chk("post_rst_pc", ex_pc, 32'h500);
        chk("post_rst_a", ex_a, 32'h77);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
